// File: rtl/i2c_tb_pkg.sv
// rtl/i2c_tb_pkg.sv - FSM states and bus acknowledge levels shared by the I2C target
package i2c_tb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ACK,
    ST_PTR,
    ST_WR,
    ST_RD,
    ST_IGNORE
  } i2c_state_e;

  localparam logic BUS_ACK  = 1'b0;
  localparam logic BUS_NACK = 1'b1;

endpackage

// File: rtl/i2c_line_filter.sv
// rtl/i2c_line_filter.sv - bus line synchronizer, FILT-deep glitch filter and edge detect
module i2c_line_filter #(
  parameter int FILT = 3
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic            sync1_q, sync1_d;
  logic [FILT-1:0] hist_q, hist_d;
  logic            level_q, level_d;
  logic            prev_q, prev_d;

  // hist_q[0] is the second synchronizer stage; the whole window must agree
  always_comb begin
    sync1_d = i_pin;
    hist_d  = (hist_q << 1) | FILT'(sync1_q);
    level_d = level_q;
    if (&hist_q) begin
      level_d = 1'b1;
    end else if (~|hist_q) begin
      level_d = 1'b0;
    end
    prev_d = level_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1_q <= 1'b1;
      hist_q  <= {FILT{1'b1}};
      level_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= sync1_d;
      hist_q  <= hist_d;
      level_q <= level_d;
      prev_q  <= prev_d;
    end
  end

  assign o_level = level_q;
  assign o_rise  = level_q & ~prev_q;
  assign o_fall  = ~level_q & prev_q;

endmodule

// File: rtl/i2c_target_regs.sv
// rtl/i2c_target_regs.sv - oversampling I2C target exposing a byte register file
module i2c_target_regs
  import i2c_tb_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h4A,
  parameter int         NREGS    = 16,
  parameter int         FILT     = 3,
  localparam int        AW       = $clog2(NREGS)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_scl,
  input  logic          i_sda,
  output logic          o_sda,
  output logic          o_sda_oe,
  output logic          o_scl_oe,
  input  logic [AW-1:0] i_reg_addr,
  input  logic          i_reg_we,
  input  logic [7:0]    i_reg_wdata,
  output logic [7:0]    o_reg_rdata,
  output logic          o_wr_valid,
  output logic [AW-1:0] o_wr_addr,
  output logic [7:0]    o_wr_data,
  output logic          o_busy
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;
  logic start, stop;

  i2c_state_e    state_q, state_d, ack_next_q, ack_next_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          sda_oe_q, sda_oe_d;
  logic          wr_valid_q, wr_valid_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic [7:0]    regs_q [NREGS];
  logic [7:0]    regs_d [NREGS];
  logic          bus_wr;
  logic [7:0]    bus_byte;

  i2c_line_filter #(.FILT(FILT)) u_scl_filt (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_pin  (i_scl),
    .o_level(scl_lvl),
    .o_rise (scl_rise),
    .o_fall (scl_fall)
  );

  i2c_line_filter #(.FILT(FILT)) u_sda_filt (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_pin  (i_sda),
    .o_level(sda_lvl),
    .o_rise (sda_rise),
    .o_fall (sda_fall)
  );

  assign start = sda_fall & scl_lvl;
  assign stop  = sda_rise & scl_lvl;

  // bit_cnt in RD: 1..8 data bits driven, 9 = master ACK slot, 10 = ACKed, reload on fall
  always_comb begin
    state_d    = state_q;
    ack_next_d = ack_next_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    ptr_d      = ptr_q;
    sda_oe_d   = sda_oe_q;
    bus_wr     = 1'b0;
    bus_byte   = {shift_q[6:0], sda_lvl};
    if (start) begin
      state_d   = ST_ADDR;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
    end else if (stop) begin
      state_d  = ST_IDLE;
      sda_oe_d = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR, ST_PTR, ST_WR: begin
          if (scl_rise && bit_cnt_q < 4'd8) begin
            shift_d   = bus_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (state_q == ST_WR && bit_cnt_q == 4'd7) begin
              bus_wr = 1'b1;
              ptr_d  = ptr_q + AW'(1);
            end
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            bit_cnt_d  = '0;
            sda_oe_d   = 1'b1;
            state_d    = ST_ACK;
            ack_next_d = ST_WR;
            if (state_q == ST_ADDR) begin
              if (shift_q[7:1] == DEV_ADDR) begin
                ack_next_d = shift_q[0] ? ST_RD : ST_PTR;
              end else begin
                sda_oe_d = 1'b0;
                state_d  = ST_IGNORE;
              end
            end else if (state_q == ST_PTR) begin
              ptr_d = shift_q[AW-1:0];
            end
          end
        end
        ST_ACK: begin
          if (scl_fall) begin
            state_d   = ack_next_q;
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
            if (ack_next_q == ST_RD) begin
              shift_d   = regs_q[ptr_q];
              sda_oe_d  = ~regs_q[ptr_q][7];
              bit_cnt_d = 4'd1;
            end
          end
        end
        ST_RD: begin
          if (scl_fall) begin
            if (bit_cnt_q < 4'd8) begin
              sda_oe_d  = ~shift_q[6];
              shift_d   = {shift_q[6:0], 1'b0};
              bit_cnt_d = bit_cnt_q + 4'd1;
            end else if (bit_cnt_q == 4'd8) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd9;
            end else if (bit_cnt_q == 4'd10) begin
              shift_d   = regs_q[ptr_q];
              sda_oe_d  = ~regs_q[ptr_q][7];
              bit_cnt_d = 4'd1;
            end
          end else if (scl_rise && bit_cnt_q == 4'd9) begin
            if (sda_lvl == BUS_NACK) begin
              state_d = ST_IGNORE;
            end else begin
              ptr_d     = ptr_q + AW'(1);
              bit_cnt_d = 4'd10;
            end
          end
        end
        ST_IGNORE: sda_oe_d = 1'b0;
        default: ;
      endcase
    end
  end

  // Bus write is applied last so it wins a same-cycle collision with the bench port
  always_comb begin
    regs_d = regs_q;
    if (i_reg_we) begin
      regs_d[i_reg_addr] = i_reg_wdata;
    end
    if (bus_wr) begin
      regs_d[ptr_q] = bus_byte;
    end
    wr_valid_d = bus_wr;
    wr_addr_d  = bus_wr ? ptr_q : wr_addr_q;
    wr_data_d  = bus_wr ? bus_byte : wr_data_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      ack_next_q <= ST_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      ptr_q      <= '0;
      sda_oe_q   <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      ack_next_q <= ack_next_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      sda_oe_q   <= sda_oe_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      regs_q     <= regs_d;
    end
  end

  assign o_sda       = 1'b0;
  assign o_sda_oe    = sda_oe_q;
  assign o_scl_oe    = 1'b0;
  assign o_reg_rdata = regs_q[i_reg_addr];
  assign o_wr_valid  = wr_valid_q;
  assign o_wr_addr   = wr_addr_q;
  assign o_wr_data   = wr_data_q;
  assign o_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_i2c_target_regs.sv
// tb/tb_i2c_target_regs.sv - bit-banged I2C initiator with register-file reference model
module tb_i2c_target_regs;
  import i2c_tb_pkg::*;

  localparam int NREGS = 16;
  localparam int AW    = 4;
  localparam int T     = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          m_scl, m_sda;
  logic          sda_line;
  logic          o_sda, o_sda_oe, o_scl_oe;
  logic [AW-1:0] i_reg_addr;
  logic          i_reg_we;
  logic [7:0]    i_reg_wdata;
  logic [7:0]    o_reg_rdata;
  logic          o_wr_valid;
  logic [AW-1:0] o_wr_addr;
  logic [7:0]    o_wr_data;
  logic          o_busy;

  int errors = 0;
  int checks = 0;

  logic [7:0]  m_regs [NREGS];
  int          m_ptr;
  logic [11:0] exp_q[$];
  logic [11:0] obs_q[$];

  assign sda_line = m_sda & ~(o_sda_oe & ~o_sda);

  always #5 clk = ~clk;

  i2c_target_regs #(.DEV_ADDR(7'h4A), .NREGS(NREGS), .FILT(3)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_scl      (m_scl),
    .i_sda      (sda_line),
    .o_sda      (o_sda),
    .o_sda_oe   (o_sda_oe),
    .o_scl_oe   (o_scl_oe),
    .i_reg_addr (i_reg_addr),
    .i_reg_we   (i_reg_we),
    .i_reg_wdata(i_reg_wdata),
    .o_reg_rdata(o_reg_rdata),
    .o_wr_valid (o_wr_valid),
    .o_wr_addr  (o_wr_addr),
    .o_wr_data  (o_wr_data),
    .o_busy     (o_busy)
  );

  always @(negedge clk) begin
    if (o_wr_valid) obs_q.push_back({o_wr_addr, o_wr_data});
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_q();
    repeat (T) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    m_sda = 1'b0; wait_q();
    m_scl = 1'b0; wait_q();
  endtask

  task automatic i2c_rstart();
    m_sda = 1'b1; wait_q();
    m_scl = 1'b1; wait_q();
    m_sda = 1'b0; wait_q();
    m_scl = 1'b0; wait_q();
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; wait_q();
    m_scl = 1'b1; wait_q();
    m_sda = 1'b1; wait_q();
  endtask

  task automatic xfer_bit(input logic b, output logic r);
    m_sda = b; wait_q();
    m_scl = 1'b1; wait_q();
    r = sda_line; wait_q();
    m_scl = 1'b0; wait_q();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) xfer_bit(d[i], r);
    xfer_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) xfer_bit(1'b1, d[i]);
    xfer_bit(mack, r);
  endtask

  task automatic model_bus_write(input logic [7:0] d);
    m_regs[m_ptr] = d;
    exp_q.push_back({4'(m_ptr), d});
    m_ptr = (m_ptr + 1) % NREGS;
  endtask

  task automatic bench_write(input int a, input logic [7:0] d);
    @(negedge clk);
    i_reg_addr = 4'(a); i_reg_wdata = d; i_reg_we = 1'b1;
    @(negedge clk);
    i_reg_we = 1'b0;
    m_regs[a] = d;
  endtask

  task automatic check_reg(input int a, input string name);
    @(negedge clk);
    i_reg_addr = 4'(a);
    #1 chk(name, 32'(o_reg_rdata), 32'(m_regs[a]));
  endtask

  task automatic check_events(input string name);
    chk({name, "_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      chk({name, "_event"}, 32'(obs_q[i]), 32'(exp_q[i]));
    obs_q.delete();
    exp_q.delete();
  endtask

  typedef struct packed {
    logic       we;
    logic [3:0] a;
    logic [7:0] wd;
    logic [7:0] exp;
  } reg_vec_t;

  typedef struct packed {
    logic [7:0] b;
    logic       exp_ack;
  } addr_vec_t;

  reg_vec_t  rv [6];
  addr_vec_t av [6];

  initial begin
    logic       ack, got;
    logic [7:0] d, pat;
    int         n, p;

    rst = 1'b1; m_scl = 1'b1; m_sda = 1'b1;
    i_reg_we = 1'b0; i_reg_addr = '0; i_reg_wdata = '0;
    for (int i = 0; i < NREGS; i++) m_regs[i] = 8'h00;
    m_ptr = 0;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_sda_oe", 32'(o_sda_oe), 0);
    chk("rst_wr_valid", 32'(o_wr_valid), 0);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_scl_oe", 32'(o_scl_oe), 0);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    check_reg(0, "rst_reg0");
    check_reg(15, "rst_reg15");

    rv[0] = '{we: 1'b1, a: 4'd3,  wd: 8'hC3, exp: 8'hC3};
    rv[1] = '{we: 1'b1, a: 4'd7,  wd: 8'h81, exp: 8'h81};
    rv[2] = '{we: 1'b0, a: 4'd3,  wd: 8'h00, exp: 8'hC3};
    rv[3] = '{we: 1'b1, a: 4'd3,  wd: 8'h00, exp: 8'h00};
    rv[4] = '{we: 1'b0, a: 4'd7,  wd: 8'hFF, exp: 8'h81};
    rv[5] = '{we: 1'b1, a: 4'd15, wd: 8'h5A, exp: 8'h5A};
    for (int i = 0; i < 6; i++) begin
      if (rv[i].we) bench_write(int'(rv[i].a), rv[i].wd);
      @(negedge clk);
      i_reg_addr = rv[i].a;
      #1 chk("regport_vec", 32'(o_reg_rdata), 32'(rv[i].exp));
    end

    av[0] = '{b: 8'h94, exp_ack: BUS_ACK};
    av[1] = '{b: 8'h96, exp_ack: BUS_NACK};
    av[2] = '{b: 8'h95, exp_ack: BUS_ACK};
    av[3] = '{b: 8'h14, exp_ack: BUS_NACK};
    av[4] = '{b: 8'h4A, exp_ack: BUS_NACK};
    av[5] = '{b: 8'hD4, exp_ack: BUS_NACK};
    for (int i = 0; i < 6; i++) begin
      i2c_start();
      write_byte(av[i].b, ack);
      chk("addr_vec_ack", 32'(ack), 32'(av[i].exp_ack));
      if (ack == BUS_ACK && av[i].b[0]) begin
        read_byte(1'b1, d);
        chk("addr_vec_rdata", 32'(d), 32'(m_regs[m_ptr]));
      end
      i2c_stop();
      chk("addr_vec_idle", 32'(o_busy), 0);
    end
    check_events("addr_vec");

    // Bus write of two data bytes at pointer 3
    i2c_start();
    write_byte(8'h94, ack); chk("t1_addr_ack", 32'(ack), 0);
    write_byte(8'h03, ack); chk("t1_ptr_ack", 32'(ack), 0);
    m_ptr = 3;
    write_byte(8'hA5, ack); chk("t1_d0_ack", 32'(ack), 0);
    model_bus_write(8'hA5);
    write_byte(8'h5A, ack); chk("t1_d1_ack", 32'(ack), 0);
    model_bus_write(8'h5A);
    i2c_stop();
    check_events("t1");
    check_reg(3, "t1_reg3");
    check_reg(4, "t1_reg4");
    chk("t1_reg4_const", 32'(o_reg_rdata), 32'h5A);

    // Read across the pointer wrap using a repeated START
    bench_write(15, 8'h11);
    bench_write(0, 8'h22);
    i2c_start();
    write_byte(8'h94, ack); chk("t2_addr_ack", 32'(ack), 0);
    write_byte(8'h0F, ack); chk("t2_ptr_ack", 32'(ack), 0);
    m_ptr = 15;
    i2c_rstart();
    write_byte(8'h95, ack); chk("t2_raddr_ack", 32'(ack), 0);
    read_byte(1'b0, d);
    chk("t2_rd0", 32'(d), 32'(m_regs[m_ptr]));
    chk("t2_rd0_const", 32'(d), 32'h11);
    m_ptr = (m_ptr + 1) % NREGS;
    read_byte(1'b1, d);
    chk("t2_rd1", 32'(d), 32'h22);
    chk("t2_released", 32'(o_sda_oe), 0);
    i2c_stop();
    check_events("t2");

    // Foreign address: nothing acknowledged, nothing written
    i2c_start();
    write_byte(8'h96, ack); chk("t3_addr_nack", 32'(ack), 1);
    write_byte(8'h07, ack); chk("t3_d0_nack", 32'(ack), 1);
    write_byte(8'h99, ack); chk("t3_d1_nack", 32'(ack), 1);
    chk("t3_busy", 32'(o_busy), 1);
    i2c_stop();
    chk("t3_idle", 32'(o_busy), 0);
    check_events("t3");
    check_reg(7, "t3_reg7");

    // Single-cycle SDA glitch while SCL is high
    repeat (20) @(posedge clk);
    @(negedge clk) m_sda = 1'b0;
    @(negedge clk) m_sda = 1'b1;
    repeat (20) @(posedge clk);
    #1 chk("t4_glitch_idle", 32'(o_busy), 0);
    i2c_start();
    chk("t4_real_start", 32'(o_busy), 1);
    i2c_stop();
    chk("t4_stop", 32'(o_busy), 0);

    // Bench write lands in the same cycle as the bus commit to register 2
    i2c_start();
    write_byte(8'h94, ack); chk("t6_addr_ack", 32'(ack), 0);
    write_byte(8'h02, ack); chk("t6_ptr_ack", 32'(ack), 0);
    m_ptr = 2;
    pat = 8'h33;
    for (int i = 7; i >= 1; i--) xfer_bit(pat[i], ack);
    @(negedge clk);
    i_reg_addr = 4'd2; i_reg_wdata = 8'h77; i_reg_we = 1'b1;
    got = 1'b0;
    fork
      xfer_bit(pat[0], ack);
      begin
        for (int k = 0; k < 200 && !got; k++) begin
          @(posedge clk);
          #1;
          if (o_wr_valid) begin
            i_reg_we = 1'b0;
            got = 1'b1;
          end
        end
        i_reg_we = 1'b0;
      end
    join
    chk("t6_commit_seen", 32'(got), 1);
    m_regs[2] = 8'h77;
    model_bus_write(8'h33);
    xfer_bit(1'b1, ack); chk("t6_d_ack", 32'(ack), 0);
    i2c_stop();
    check_events("t6");
    check_reg(2, "t6_reg2");
    chk("t6_reg2_const", 32'(o_reg_rdata), 32'h33);

    // Random writes and reads against the reference model
    for (int t = 0; t < 8; t++) begin
      n = int'($urandom_range(1, 3));
      p = int'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 0) begin
        i2c_start();
        write_byte(8'h94, ack); chk("rnd_w_addr_ack", 32'(ack), 0);
        write_byte(8'(p), ack); chk("rnd_w_ptr_ack", 32'(ack), 0);
        m_ptr = p % NREGS;
        for (int k = 0; k < n; k++) begin
          d = 8'($urandom);
          write_byte(d, ack); chk("rnd_w_data_ack", 32'(ack), 0);
          model_bus_write(d);
        end
        i2c_stop();
        check_events("rnd_w");
      end else begin
        i2c_start();
        if ($urandom_range(0, 1) == 1) begin
          write_byte(8'h94, ack); chk("rnd_r_addr_ack", 32'(ack), 0);
          write_byte(8'(p), ack); chk("rnd_r_ptr_ack", 32'(ack), 0);
          m_ptr = p % NREGS;
          i2c_rstart();
        end
        write_byte(8'h95, ack); chk("rnd_r_raddr_ack", 32'(ack), 0);
        for (int k = 0; k < n; k++) begin
          read_byte((k == n - 1) ? BUS_NACK : BUS_ACK, d);
          chk("rnd_r_data", 32'(d), 32'(m_regs[m_ptr]));
          if (k != n - 1) m_ptr = (m_ptr + 1) % NREGS;
        end
        i2c_stop();
        check_events("rnd_r");
      end
    end

    // Reset while the target pulls SDA low for a 0 data bit
    bench_write(5, 8'h3C);
    i2c_start();
    write_byte(8'h94, ack); chk("t5_addr_ack", 32'(ack), 0);
    write_byte(8'h05, ack); chk("t5_ptr_ack", 32'(ack), 0);
    i2c_rstart();
    write_byte(8'h95, ack); chk("t5_raddr_ack", 32'(ack), 0);
    chk("t5_drive_low", 32'(o_sda_oe), 1);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1 chk("t5_rst_release", 32'(o_sda_oe), 0);
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < NREGS; i++) m_regs[i] = 8'h00;
    m_ptr = 0;
    obs_q.delete();
    exp_q.delete();
    check_reg(5, "t5_reg5_cleared");
    wait_q();
    m_scl = 1'b1;
    wait_q();
    wait_q();
    i2c_start();
    write_byte(8'h94, ack); chk("t5_post_addr_ack", 32'(ack), 0);
    write_byte(8'h01, ack); chk("t5_post_ptr_ack", 32'(ack), 0);
    m_ptr = 1;
    write_byte(8'h5E, ack); chk("t5_post_data_ack", 32'(ack), 0);
    model_bus_write(8'h5E);
    i2c_stop();
    check_events("t5");
    check_reg(1, "t5_reg1");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
